// File: rtl/playback_sequencer.sv
// Purpose : walks a queue of playback segments through the clear -> load -> wait -> gap -> play cycle.
// Latency : ctl_clear 1 cycle after start, ctl_start 2 cycles after, pb_enable GAP_CYCLES+1 after ctl_data_valid.
// Backpr. : cmd_ready drops while the segment queue is full; pushes arriving while full are discarded.
module playback_sequencer #(
   parameter int QUEUE_DEPTH = 4,
   parameter int ADDR_W      = 16,
   parameter int LEN_W       = 16,
   parameter int GAP_CYCLES  = 50,
   parameter int TIMEOUT     = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [ADDR_W-1:0]              cmd_addr,
   input  logic [LEN_W-1:0]               cmd_len,
   input  logic [7:0]                     cmd_repeat,
   input  logic                           start,
   input  logic                           abort,
   output logic                           ctl_clear,
   output logic                           ctl_start,
   output logic [ADDR_W-1:0]              ctl_request_addr,
   output logic [LEN_W-1:0]               ctl_num_reads,
   input  logic                           ctl_data_valid,
   output logic                           pb_enable,
   input  logic                           pb_complete,
   output logic                           busy,
   output logic                           seg_done,
   output logic                           all_done,
   output logic                           error,
   output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [7:0]        rpt;
   } seg_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      WAIT_VALID,
      GAP,
      PLAY,
      NEXT
   } state_t;

   state_t            state;
   state_t            nextState;

   // segment queue storage and bookkeeping
   seg_t              queueMem [QUEUE_DEPTH];
   logic [PTR_W-1:0]  rdPtr;
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W:0]    count;
   logic              full;
   logic              empty;
   logic              pushAcc;
   logic              popNow;
   seg_t              cmdSeg;
   logic [PTR_W-1:0]  headIdxNext;
   seg_t              headNext;

   // active segment context
   logic [ADDR_W-1:0] addrReg;
   logic [LEN_W-1:0]  lenReg;
   logic [7:0]        passCnt;
   logic [GAP_W-1:0]  gapCnt;
   logic [TO_W-1:0]   toCnt;

   // FSM side effects
   logic              loadSeg;
   logic              decPass;
   logic              setError;
   logic              clrError;
   logic              armClear;
   logic              allDoneSet;
   logic              clearPulse;
   logic              allDoneReg;
   logic              errorReg;

   assign cmdSeg  = '{addr: cmd_addr, len: cmd_len, rpt: cmd_repeat};
   assign full    = (count == (PTR_W + 1)'(QUEUE_DEPTH));
   assign empty   = (count == '0);
   // Full is judged on registered occupancy only, so a pop in the same cycle never opens a slot early.
   // Abort discards any push arriving with it.
   assign pushAcc = cmd_valid && !full && !abort;

   // The entry that will be at the head after this edge. When the queue drains to empty in the
   // same cycle as a push, the new entry becomes the head before it reaches the memory, so bypass it.
   assign headIdxNext = popNow ? (rdPtr + PTR_W'(1)) : rdPtr;
   assign headNext    = (pushAcc && (wrPtr == headIdxNext)) ? cmdSeg : queueMem[headIdxNext];

   // Queue write port; storage needs no reset since occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (pushAcc) begin
         queueMem[wrPtr] <= cmdSeg;
      end
   end

   // Queue pointers and occupancy; abort flushes everything.
   always_ff @(posedge clk) begin
      if (reset || abort) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (pushAcc) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (popNow) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         count <= count + (PTR_W + 1)'(pushAcc) - (PTR_W + 1)'(popNow);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      nextState  = state;
      popNow     = 1'b0;
      loadSeg    = 1'b0;
      decPass    = 1'b0;
      setError   = 1'b0;
      clrError   = 1'b0;
      armClear   = 1'b0;
      allDoneSet = 1'b0;
      seg_done   = 1'b0;
      if (abort) begin
         // Abort wins over everything; in IDLE it only flushes the queue.
         if (state != IDLE) begin
            nextState = IDLE;
            armClear  = 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (!empty) begin
                     nextState = CLEAR;
                     loadSeg   = 1'b1;
                     clrError  = 1'b1;
                  end else begin
                     allDoneSet = 1'b1;
                  end
               end
            end
            CLEAR: begin
               if (lenReg == '0) begin
                  nextState = NEXT;
               end else begin
                  nextState = LOAD;
               end
            end
            LOAD: begin
               nextState = WAIT_VALID;
            end
            WAIT_VALID: begin
               if (ctl_data_valid) begin
                  if (GAP_CYCLES == 0) begin
                     nextState = PLAY;
                  end else begin
                     nextState = GAP;
                  end
               end else if (int'(toCnt) >= TIMEOUT - 1) begin
                  // Give up on this segment but keep the rest of the queue for a later start.
                  nextState = IDLE;
                  setError  = 1'b1;
                  popNow    = 1'b1;
                  armClear  = 1'b1;
               end
            end
            GAP: begin
               if (int'(gapCnt) >= GAP_CYCLES - 1) begin
                  nextState = PLAY;
               end
            end
            PLAY: begin
               if (pb_complete) begin
                  nextState = NEXT;
               end
            end
            NEXT: begin
               if (passCnt != 8'd0) begin
                  // Another pass: same address/length, reloaded from BRAM.
                  decPass   = 1'b1;
                  nextState = CLEAR;
               end else begin
                  popNow   = 1'b1;
                  seg_done = 1'b1;
                  if ((count == (PTR_W + 1)'(1)) && !pushAcc) begin
                     allDoneSet = 1'b1;
                     nextState  = IDLE;
                  end else begin
                     loadSeg   = 1'b1;
                     nextState = CLEAR;
                  end
               end
            end
            default: begin
               nextState = IDLE;
            end
         endcase
      end
   end

   // Segment context is captured on entry to CLEAR so address/length are already valid in the CLEAR cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         addrReg <= '0;
         lenReg  <= '0;
         passCnt <= '0;
      end else if (loadSeg) begin
         addrReg <= headNext.addr;
         lenReg  <= headNext.len;
         passCnt <= headNext.rpt;
      end else if (decPass) begin
         passCnt <= passCnt - 8'd1;
      end
   end

   // Gap counter: runs only inside GAP, saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset || (state != GAP)) begin
         gapCnt <= '0;
      end else if (int'(gapCnt) < GAP_CYCLES) begin
         gapCnt <= gapCnt + GAP_W'(1);
      end
   end

   // Load timeout counter: runs only inside WAIT_VALID, saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset || (state != WAIT_VALID)) begin
         toCnt <= '0;
      end else if (int'(toCnt) < TIMEOUT) begin
         toCnt <= toCnt + TO_W'(1);
      end
   end

   // Registered status pulses and the sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         clearPulse <= 1'b0;
         allDoneReg <= 1'b0;
         errorReg   <= 1'b0;
      end else begin
         clearPulse <= armClear;
         allDoneReg <= allDoneSet;
         if (setError) begin
            errorReg <= 1'b1;
         end else if (clrError) begin
            errorReg <= 1'b0;
         end
      end
   end

   assign cmd_ready        = !full;
   assign queue_count      = count;
   assign busy             = (state != IDLE);
   assign ctl_clear        = (state == CLEAR) || clearPulse;
   assign ctl_start        = (state == LOAD);
   assign pb_enable        = (state == PLAY);
   assign ctl_request_addr = addrReg;
   assign ctl_num_reads    = lenReg;
   assign all_done         = allDoneReg;
   assign error            = errorReg;

endmodule
